// File: rtl/tile_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tile_rom_arbiter
//
// Round-robin arbiter that lets up to four requesters share one set of six
// tile colour ROMs. A grant is combinational. The granted request then moves
// through a three-stage pipeline:
//   stage 1 : registers the ROM read address, type, requester id and error flag
//   stage 2 : lines up type/id/error with the data coming out of the ROMs
//   stage 3 : registers the response (colour nibble or error)
//
// Ports
//   Clk, Reset            sole clock, synchronous active-high reset
//   req[N_REQ]            per-requester fetch request
//   req_type[3*N_REQ]     ROM select per requester (0..5 valid, 6..7 invalid)
//   req_px[6*N_REQ]       pixel x within the tile
//   req_py[5*N_REQ]       pixel y within the tile
//   gnt[N_REQ]            one-hot grant, combinational
//   read_address[13]      registered address broadcast to all tile ROMs
//   rom_color_bus[24]     ROM k colour index on bits [4k+3:4k]
//   rsp_valid/id/color/err registered response, three cycles after the grant
// ---------------------------------------------------------------------------
module tile_rom_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TILE_H = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_type,
  input  logic [6*N_REQ-1:0] req_px,
  input  logic [5*N_REQ-1:0] req_py,
  output logic [N_REQ-1:0]   gnt,
  output logic [12:0]        read_address,
  input  logic [23:0]        rom_color_bus,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [3:0]         rsp_color,
  output logic               rsp_err
);

  localparam logic [1:0] IDX_LAST  = 2'(N_REQ - 1);
  localparam logic [5:0] TILE_H_L  = 6'(TILE_H);

  // Requester fields padded out to four slots so the 2-bit index is always
  // exactly wide enough, whatever N_REQ is.
  logic       req_ext  [4];
  logic [2:0] type_arr [4];
  logic [5:0] px_arr   [4];
  logic [4:0] py_arr   [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    if (gi < N_REQ) begin : g_used
      assign req_ext[gi]  = req[gi];
      assign type_arr[gi] = req_type[3*gi +: 3];
      assign px_arr[gi]   = req_px[6*gi +: 6];
      assign py_arr[gi]   = req_py[5*gi +: 5];
    end else begin : g_unused
      assign req_ext[gi]  = 1'b0;
      assign type_arr[gi] = 3'd0;
      assign px_arr[gi]   = 6'd0;
      assign py_arr[gi]   = 5'd0;
    end
  end

  logic [1:0]  ptr_q, ptr_d;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [3:0]  gnt_ext;

  // Search starts at the pointer and wraps; first requesting slot wins.
  always_comb begin
    int cand;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr_q) + off) % N_REQ;
      if (!win_valid && req_ext[cand]) begin
        win_valid = 1'b1;
        win_idx   = 2'(cand);
      end
    end
    // No grants while in reset, so nothing can enter the pipeline.
    if (Reset) begin
      win_valid = 1'b0;
    end
    gnt_ext = 4'd0;
    if (win_valid) begin
      gnt_ext[win_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (win_valid) begin
      ptr_d = (win_idx == IDX_LAST) ? 2'd0 : win_idx + 2'd1;
    end
  end

  assign gnt = gnt_ext[N_REQ-1:0];

  // Address and error check for the winning request.
  logic [2:0]  sel_type;
  logic [5:0]  sel_px;
  logic [4:0]  sel_py;
  logic [5:0]  sel_w;
  logic        sel_err;
  logic [12:0] sel_addr;

  always_comb begin
    sel_type = type_arr[win_idx];
    sel_px   = px_arr[win_idx];
    sel_py   = py_arr[win_idx];
    // Arrow tile (type 5) is twice as wide as the others.
    sel_w    = (sel_type == 3'd5) ? 6'd40 : 6'd20;
    sel_err  = (sel_type > 3'd5) || (sel_px >= sel_w) || ({1'b0, sel_py} >= TILE_H_L);
    // 31*40+63 = 1303 fits comfortably in 13 bits.
    sel_addr = 13'(sel_py) * 13'(sel_w) + 13'(sel_px);
  end

  // Pipeline state.
  logic [12:0] read_address_q;
  logic        s1_valid_q, s2_valid_q;
  logic [2:0]  s1_type_q, s2_type_q;
  logic [1:0]  s1_id_q, s2_id_q;
  logic        s1_err_q, s2_err_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_id_q;
  logic [3:0]  rsp_color_q;
  logic        rsp_err_q;
  logic [3:0]  color_d;

  // ROM data is valid while the request sits in stage 2.
  always_comb begin
    color_d = 4'd0;
    if (!s2_err_q) begin
      case (s2_type_q)
        3'd0:    color_d = rom_color_bus[3:0];
        3'd1:    color_d = rom_color_bus[7:4];
        3'd2:    color_d = rom_color_bus[11:8];
        3'd3:    color_d = rom_color_bus[15:12];
        3'd4:    color_d = rom_color_bus[19:16];
        3'd5:    color_d = rom_color_bus[23:20];
        default: color_d = 4'd0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q          <= 2'd0;
      read_address_q <= 13'd0;
      s1_valid_q     <= 1'b0;
      s1_type_q      <= 3'd0;
      s1_id_q        <= 2'd0;
      s1_err_q       <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_type_q      <= 3'd0;
      s2_id_q        <= 2'd0;
      s2_err_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 2'd0;
      rsp_color_q    <= 4'd0;
      rsp_err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= win_valid;
      // Address holds its last value when nothing is granted.
      if (win_valid) begin
        read_address_q <= sel_err ? 13'd0 : sel_addr;
        s1_type_q      <= sel_type;
        s1_id_q        <= win_idx;
        s1_err_q       <= sel_err;
      end
      s2_valid_q  <= s1_valid_q;
      s2_type_q   <= s1_type_q;
      s2_id_q     <= s1_id_q;
      s2_err_q    <= s1_err_q;
      rsp_valid_q <= s2_valid_q;
      rsp_id_q    <= s2_id_q;
      rsp_color_q <= color_d;
      rsp_err_q   <= s2_err_q;
    end
  end

  assign read_address = read_address_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_color    = rsp_color_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tile_rom_arbiter
//
// Directed bench for tile_rom_arbiter (N_REQ = 3, TILE_H = 20). Inputs are
// driven on the falling edge; grants are checked 1 ns later and registered
// outputs are checked on falling edges. The ROM colour bus is held constant:
// slices 0..5 = 7, 2, 3, 4, 5, C.
// ---------------------------------------------------------------------------
module tb_tile_rom_arbiter;

  logic        Clk;
  logic        Reset;
  logic [2:0]  req;
  logic [8:0]  req_type;
  logic [17:0] req_px;
  logic [14:0] req_py;
  logic [2:0]  gnt;
  logic [12:0] read_address;
  logic [23:0] rom_color_bus;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_color;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  tile_rom_arbiter #(.N_REQ(3), .TILE_H(20)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .req          (req),
    .req_type     (req_type),
    .req_px       (req_px),
    .req_py       (req_py),
    .gnt          (gnt),
    .read_address (read_address),
    .rom_color_bus(rom_color_bus),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_color    (rsp_color),
    .rsp_err      (rsp_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic set_fields(input int i, input logic [2:0] t, input logic [5:0] x,
                            input logic [4:0] y);
    req_type[3*i +: 3] = t;
    req_px[6*i +: 6]   = x;
    req_py[5*i +: 5]   = y;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req   = 3'b111;
    set_fields(0, 3'd0, 6'd1, 5'd1);
    set_fields(1, 3'd1, 6'd2, 5'd2);
    set_fields(2, 3'd2, 6'd3, 5'd3);
    repeat (3) @(negedge Clk);
    #1;
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    n_checks++; if (read_address !== 13'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", read_address); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0 || rsp_color !== 4'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got id=%0d color=%0h err=%b expected 0 0 0", rsp_id, rsp_color, rsp_err);
    end
    $display("reset: gnt=%b addr=%0d rsp_valid=%b", gnt, read_address, rsp_valid);
    req = 3'b000;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge Clk);
    req = 3'b001;
    set_fields(0, 3'd0, 6'd3, 5'd2);
    #1;
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt: got %b expected 001", gnt); end
    @(negedge Clk);
    req = 3'b000;
    n_checks++; if (read_address !== 13'd43) begin n_fail++; $display("FAIL single_addr: got %0d expected 43", read_address); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid_t1: got %b expected 0", rsp_valid); end
    @(negedge Clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid_t2: got %b expected 0", rsp_valid); end
    @(negedge Clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_color !== 4'h7 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got v=%b id=%0d color=%0h err=%b expected 1 0 7 0", rsp_valid, rsp_id, rsp_color, rsp_err);
    end
    $display("single: addr=43 rsp id=%0d color=%0h err=%b", rsp_id, rsp_color, rsp_err);
    @(negedge Clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_arrow();
    // Pointer is 1 after the single fetch by requester 0.
    @(negedge Clk);
    req = 3'b010;
    set_fields(1, 3'd5, 6'd39, 5'd19);
    #1;
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL arrow_gnt: got %b expected 010", gnt); end
    @(negedge Clk);
    req = 3'b000;
    n_checks++; if (read_address !== 13'd799) begin n_fail++; $display("FAIL arrow_addr: got %0d expected 799", read_address); end
    repeat (2) @(negedge Clk);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_color !== 4'hC || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL arrow_rsp: got v=%b id=%0d color=%0h err=%b expected 1 1 c 0", rsp_valid, rsp_id, rsp_color, rsp_err);
    end
    $display("arrow: addr=%0d rsp id=%0d color=%0h", read_address, rsp_id, rsp_color);
  endtask

  task automatic test_errors();
    // Pointer starts at 2. Entries: requester, type, px, py, addr, color, err.
    int         who [4] = '{2, 0, 1, 2};
    logic [2:0] ty  [4] = '{3'd1, 3'd4, 3'd6, 3'd0};
    logic [5:0] px  [4] = '{6'd20, 6'd19, 6'd0, 6'd0};
    logic [4:0] py  [4] = '{5'd0, 5'd19, 5'd0, 5'd20};
    int         ea  [4] = '{0, 399, 0, 0};
    logic [3:0] ec  [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
    logic       ee  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] g;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      g = 3'b000;
      g[who[k]] = 1'b1;
      req = g;
      set_fields(who[k], ty[k], px[k], py[k]);
      #1;
      n_checks++; if (gnt !== g) begin n_fail++; $display("FAIL err%0d_gnt: got %b expected %b", k, gnt, g); end
      @(negedge Clk);
      req = 3'b000;
      n_checks++; if (read_address !== 13'(ea[k])) begin n_fail++; $display("FAIL err%0d_addr: got %0d expected %0d", k, read_address, ea[k]); end
      repeat (2) @(negedge Clk);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(who[k]) || rsp_color !== ec[k] || rsp_err !== ee[k]) begin
        n_fail++; $display("FAIL err%0d_rsp: got v=%b id=%0d color=%0h err=%b expected 1 %0d %0h %b",
                           k, rsp_valid, rsp_id, rsp_color, rsp_err, who[k], ec[k], ee[k]);
      end
      $display("errcase %0d: type=%0d px=%0d py=%0d addr=%0d color=%0h err=%b", k, ty[k], px[k], py[k], read_address, rsp_color, rsp_err);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] t_req [7] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] e_gnt [7] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    int         e_adr [7] = '{0, 1, 20, 105, 105, 105, 105};
    logic       e_v   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] e_id  [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [3:0] e_col [7] = '{4'h0, 4'h0, 4'h0, 4'h7, 4'h3, 4'h4, 4'h0};
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    set_fields(0, 3'd0, 6'd1, 5'd0);
    set_fields(1, 3'd2, 6'd0, 5'd1);
    set_fields(2, 3'd3, 6'd5, 5'd5);
    for (int c = 0; c < 7; c++) begin
      @(negedge Clk);
      req = t_req[c];
      #1;
      n_checks++; if (gnt !== e_gnt[c]) begin n_fail++; $display("FAIL fair_gnt c%0d: got %b expected %b", c, gnt, e_gnt[c]); end
      n_checks++; if (read_address !== 13'(e_adr[c])) begin n_fail++; $display("FAIL fair_addr c%0d: got %0d expected %0d", c, read_address, e_adr[c]); end
      n_checks++; if (rsp_valid !== e_v[c]) begin n_fail++; $display("FAIL fair_valid c%0d: got %b expected %b", c, rsp_valid, e_v[c]); end
      if (e_v[c]) begin
        n_checks++; if (rsp_id !== e_id[c] || rsp_color !== e_col[c] || rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL fair_rsp c%0d: got id=%0d color=%0h err=%b expected %0d %0h 0", c, rsp_id, rsp_color, rsp_err, e_id[c], e_col[c]);
        end
      end
      $display("fair c%0d: req=%b gnt=%b addr=%0d v=%b id=%0d color=%0h", c, req, gnt, read_address, rsp_valid, rsp_id, rsp_color);
    end
  endtask

  task automatic test_contention();
    logic [2:0] t_req [8] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] e_gnt [8] = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    int         e_adr [8] = '{0, 64, 22, 64, 22, 22, 22, 22};
    logic       e_v   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] e_id  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    logic [3:0] e_col [8] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h5, 4'h2, 4'h5, 4'h0};
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    set_fields(0, 3'd1, 6'd4, 5'd3);
    set_fields(2, 3'd4, 6'd2, 5'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      req = t_req[c];
      #1;
      n_checks++; if (gnt !== e_gnt[c]) begin n_fail++; $display("FAIL cont_gnt c%0d: got %b expected %b", c, gnt, e_gnt[c]); end
      n_checks++; if (read_address !== 13'(e_adr[c])) begin n_fail++; $display("FAIL cont_addr c%0d: got %0d expected %0d", c, read_address, e_adr[c]); end
      n_checks++; if (rsp_valid !== e_v[c]) begin n_fail++; $display("FAIL cont_valid c%0d: got %b expected %b", c, rsp_valid, e_v[c]); end
      if (e_v[c]) begin
        n_checks++; if (rsp_id !== e_id[c] || rsp_color !== e_col[c] || rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL cont_rsp c%0d: got id=%0d color=%0h err=%b expected %0d %0h 0", c, rsp_id, rsp_color, rsp_err, e_id[c], e_col[c]);
        end
      end
      $display("cont c%0d: req=%b gnt=%b addr=%0d v=%b id=%0d color=%0h", c, req, gnt, read_address, rsp_valid, rsp_id, rsp_color);
    end
  endtask

  task automatic test_reset_midflight();
    // Pointer is 0 here (last contention grant went to requester 2).
    @(negedge Clk);
    req = 3'b001;
    set_fields(0, 3'd0, 6'd1, 5'd1);
    set_fields(1, 3'd0, 6'd2, 5'd0);
    set_fields(2, 3'd0, 6'd3, 5'd0);
    #1;
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL mid_gnt_t0: got %b expected 001", gnt); end
    @(negedge Clk);
    req = 3'b010;
    #1;
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL mid_gnt_t1: got %b expected 010", gnt); end
    n_checks++; if (read_address !== 13'd21) begin n_fail++; $display("FAIL mid_addr_t1: got %0d expected 21", read_address); end
    @(negedge Clk);
    Reset = 1'b1;
    req   = 3'b111;
    #1;
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL mid_gnt_in_reset: got %b expected 000", gnt); end
    n_checks++; if (read_address !== 13'd2) begin n_fail++; $display("FAIL mid_addr_t2: got %0d expected 2", read_address); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_t2: got %b expected 0", rsp_valid); end
    @(negedge Clk);
    Reset = 1'b0;
    req   = 3'b000;
    n_checks++; if (read_address !== 13'd0) begin n_fail++; $display("FAIL mid_addr_after_reset: got %0d expected 0", read_address); end
    for (int c = 3; c <= 5; c++) begin
      if (c > 3) @(negedge Clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_t%0d: got %b expected 0", c, rsp_valid); end
    end
    @(negedge Clk);
    req = 3'b111;
    #1;
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL mid_ptr_after_reset: got %b expected 001", gnt); end
    $display("midflight: post-reset gnt=%b", gnt);
    @(negedge Clk);
    req = 3'b000;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset         = 1'b1;
    req           = 3'b000;
    req_type      = '0;
    req_px        = '0;
    req_py        = '0;
    rom_color_bus = 24'hC54327;
    test_reset();
    test_single();
    test_arrow();
    test_errors();
    test_fairness();
    test_contention();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_rom_arbiter.md
TILE_ROM_ARBITER -- requirements
Module: tile_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter TILE_H, default 20, tile height in pixels for all ROMs.
REQ-003 SHALL have ports Clk (in, 1, sole clock) and Reset (in, 1, synchronous, active-high).
REQ-004 SHALL have req (in, N_REQ): per-requester fetch request, held until granted.
REQ-005 SHALL have req_type (in, 3*N_REQ): ROM select per requester. 0 brick_ground, 1 spine, 2 spine_move, 3 save_point, 4 save_point2, 5 arrow_right, 6-7 invalid.
REQ-006 SHALL have req_px (in, 6*N_REQ) and req_py (in, 5*N_REQ): pixel coordinates within the tile.
REQ-007 SHALL have gnt (out, N_REQ): one-hot grant, combinational, same cycle as the winning req.
REQ-008 SHALL have read_address (out, 13): registered address broadcast to all six tile ROMs.
REQ-009 SHALL have rom_color_bus (in, 24): ROM k color_idx on bits [4k+3:4k], k=0..5.
REQ-010 SHALL have rsp_valid (out, 1), rsp_id (out, 2), rsp_color (out, 4) and rsp_err (out, 1): registered response.

Function
REQ-011 SHALL compute gnt combinationally from req and a round-robin pointer: first set req bit at or after the pointer, wrapping; gnt = 0 when req = 0.
REQ-012 SHALL update the pointer on any grant to (granted index + 1) mod N_REQ and hold it otherwise.
REQ-013 SHALL use tile width 40 for type 5 and 20 for types 0-4.
REQ-014 SHALL compute address = py*width + px in at least 13 bits with no truncation; max legal value is 799.
REQ-015 SHALL flag a grant as an error when type > 5, px >= width or py >= TILE_H; for an error grant, read_address = 0 and no ROM data is used.
REQ-016 Stage 1: a grant in cycle T SHALL register read_address, type, requester id and error flag, all visible in T+1.
REQ-017 Stage 2: type, id, error flag and a valid bit SHALL advance one stage in T+2, aligned with ROM output data.
REQ-018 Stage 3 output SHALL be registered in T+3:
- rsp_valid = 1, rsp_id = granted index
- rsp_color = rom_color_bus slice selected by stage-2 type, or 0 when error
- rsp_err = error flag
REQ-019 Latency from grant to rsp_valid SHALL be exactly 3 cycles.
REQ-020 Throughput SHALL be one grant per cycle; back-to-back responses SHALL be in grant order with no bubbles.
REQ-021 A requester SHALL deassert or change req on the edge after its gnt; a req still held is treated as a new request.
REQ-022 read_address SHALL hold its last value in cycles with no grant.
REQ-023 rsp_valid SHALL be 0 in any cycle with no corresponding grant three cycles earlier; rsp_id, rsp_color and rsp_err are don't-care when rsp_valid = 0.

Reset
REQ-024 Reset SHALL set:
- pointer = 0, all pipeline valid bits = 0, read_address = 0
- rsp_valid = 0, rsp_id = 0, rsp_color = 0, rsp_err = 0
REQ-025 Reset asserted mid-operation SHALL discard every in-flight request; no rsp_valid for grants made before or during Reset.
REQ-026 gnt SHALL be 0 while Reset = 1.

Verification
REQ-027 Single fetch: req = 001, type 0, px 3, py 2 in cycle T -> gnt = 001 in T, read_address = 43 in T+1; with bus slice0 = 0x7, rsp_valid = 1, rsp_id = 0, rsp_color = 7, rsp_err = 0 in T+3.
REQ-028 Arrow corner: type 5, px 39, py 19 -> read_address = 799; response color = bus slice5.
REQ-029 Fairness: after Reset, req = 111 held, each requester drops req after its grant -> gnt = 001, 010, 100 in consecutive cycles; rsp_id = 0, 1, 2 on cycles T+3..T+5.
REQ-030 Continuous contention: requesters 0 and 2 always requesting -> gnt alternates 001, 100, 001, 100 with no starvation.
REQ-031 Errors: type 1 with px 20 -> read_address = 0, rsp_err = 1, rsp_color = 0 at T+3; type 6 with px 0, py 0 -> same error response.
REQ-032 Reset mid-flight: grants in T and T+1, Reset high in T+2 -> rsp_valid = 0 through T+5, and pointer = 0 afterwards.
